wkup_bcast: RTL
===============

Name: wkup_bcast

Overview:
- Producer end of the operand wakeup interface: collects completed results from execution units and broadcasts them on WKUP_COUNT wakeup channels.
- Tag/valid is broadcast in cycle T; the matching data is driven in cycle T+1. This matches consumers that register a hit in T and select forwarded data in T+1.
- Sits between FU writeback ports and the issue queues / operand wakeup stages.

Parameters:
- FU_COUNT, 4, number of result-producing sources.
- WKUP_COUNT, 2, number of broadcast channels; must be <= FU_COUNT.
- DEPTH, 2, per-source buffer entries; power of two, >= 2.
- TAG_W, 6, physical register tag width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; drops all buffered and in-flight broadcasts
- fu_valid_i  in  FU_COUNT  source result valid
- fu_ready_o  out  FU_COUNT  source buffer can accept
- fu_tag_i  in  FU_COUNT x TAG_W  destination tag per source
- fu_data_i  in  FU_COUNT x word_t  result data per source
- wkup_valid_o  out  WKUP_COUNT  channel broadcasting a tag this cycle
- wkup_tag_o  out  WKUP_COUNT x TAG_W  broadcast tag
- wkup_data_o  out  WKUP_COUNT x word_t  data for the tag broadcast on that channel in the previous cycle

Behaviour:
- Reset (async, rst_n low): all buffers empty, all pointers/counts zero, rr_ptr=0. wkup_valid_o=0, wkup_tag_o=0, wkup_data_o=0. fu_ready_o goes high on the first cycle after reset release.
- Per-source FIFO:
  - Depth DEPTH; holds {tag, data}; circular rd/wr pointers plus count.
  - fu_ready_o[s] = (count[s] != DEPTH). It is derived from registered count only; a same-cycle pop does not raise it.
  - Push when fu_valid_i[s] && fu_ready_o[s] && !flush.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop: count unchanged.
- Arbitration (combinational on FIFO heads, every cycle flush is low):
  - Scan sources in order rr_ptr, rr_ptr+1, ... modulo FU_COUNT.
  - The first up-to-WKUP_COUNT non-empty sources are granted to channels 0, 1, ... in scan order.
  - Each granted source pops exactly one entry. A source is granted at most once per cycle.
  - rr_ptr becomes (last granted source + 1) mod FU_COUNT. If nothing is granted, rr_ptr is unchanged.
- Tag stage (registered):
  - At clock edge after grant: wkup_valid_o[c]=1 and wkup_tag_o[c]=granted tag. Granted data is held in an internal stage register.
  - Ungranted channels: valid=0, tag holds its previous value.
- Data stage (registered):
  - At each edge, wkup_data_o[c] <= internal data for channel c. wkup_data_o therefore lags wkup_valid_o/tag_o by exactly one cycle.
  - Updated every cycle regardless of valid, so it is a don't-care when the prior valid was 0.
- Latency:
  - Push at edge E into an empty FIFO with the source winning arbitration: tag visible after E+1, data after E+2.
  - Minimum source-to-tag latency is 1 cycle after the entry is buffered.
- Flush:
  - Clears all FIFO counts/pointers and all wkup_valid_o at the next edge. Pushes in the flush cycle are dropped and no grants are made.
  - rr_ptr is not reset.
  - wkup_data_o still updates from the stage register. This is harmless because consumers saw no valid hit.
- Full with all sources valid: no loss. Sources stall via fu_ready_o. Throughput is WKUP_COUNT results per cycle.
- Fewer than WKUP_COUNT non-empty sources: only the low-index channels are used.
- Tags are passed through unchecked. Duplicate tags are the producer's responsibility.

Optional Feature:
- Macro: WKUP_BCAST_STAT_EN.
- Defined: adds output stall_cnt_o (32-bit) and its counter.
  - Increments once per cycle in which any source has fu_valid_i=1 and fu_ready_o=0.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset only, not by flush.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Single push, source 2 tag=0x15 data=0xDEADBEEF at edge E → wkup_valid_o[0]=1, tag=0x15 after E+1; wkup_data_o[0]=0xDEADBEEF after E+2; channel 1 valid=0.
- All 4 sources push one entry each (tags 1,2,3,4) with rr_ptr=0 → cycle 1: channels carry tags 1,2; cycle 2: tags 3,4; rr_ptr returns to 0; data follows each tag by one cycle.
- Source 0 pushes 3 back-to-back with WKUP_COUNT=2 and no other traffic → one grant per cycle, tags in push order; fu_ready_o[0] drops only when count=2; no entry lost.
- Fill all FIFOs, then assert flush for 1 cycle → next cycle all wkup_valid_o=0; fu_ready_o all 1; a push during the flush cycle is never broadcast.
- Assert rst_n low mid-stream with FIFOs half full → outputs go to 0 immediately (asynchronously); after release no stale tag is ever broadcast.
- With WKUP_BCAST_STAT_EN: hold source 1 valid while its FIFO is full for 5 cycles → stall_cnt_o increases by exactly 5.

Source files
------------

// File: rtl/wkup_bcast_if.sv
// rtl/wkup_bcast_if.sv - FU writeback and wakeup broadcast bus bundle
interface wkup_bcast_if #(
    parameter int FU_COUNT   = 4,
    parameter int WKUP_COUNT = 2,
    parameter int TAG_W      = 6,
    parameter int DATA_W     = 32
);
    logic [FU_COUNT-1:0]                  fu_valid_i;
    logic [FU_COUNT-1:0]                  fu_ready_o;
    logic [FU_COUNT-1:0][TAG_W-1:0]       fu_tag_i;
    logic [FU_COUNT-1:0][DATA_W-1:0]      fu_data_i;
    logic [WKUP_COUNT-1:0]                wkup_valid_o;
    logic [WKUP_COUNT-1:0][TAG_W-1:0]     wkup_tag_o;
    logic [WKUP_COUNT-1:0][DATA_W-1:0]    wkup_data_o;

    modport master (
        output fu_valid_i, fu_tag_i, fu_data_i,
        input  fu_ready_o, wkup_valid_o, wkup_tag_o, wkup_data_o
    );

    modport slave (
        input  fu_valid_i, fu_tag_i, fu_data_i,
        output fu_ready_o, wkup_valid_o, wkup_tag_o, wkup_data_o
    );
endinterface

// File: rtl/wkup_bcast.sv
// rtl/wkup_bcast.sv - wakeup broadcaster: per-FU FIFOs, round-robin onto channels, tag in T, data in T+1
// Optional stall counter output stall_cnt_o enabled by WKUP_BCAST_STAT_EN.
module wkup_bcast #(
    parameter int FU_COUNT   = 4,
    parameter int WKUP_COUNT = 2,
    parameter int DEPTH      = 2,
    parameter int TAG_W      = 6,
    parameter int DATA_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    wkup_bcast_if.slave      bus
`ifdef WKUP_BCAST_STAT_EN
    ,
    output logic [31:0]      stall_cnt_o
`endif
);
    localparam int SRC_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [DATA_W-1:0] word_t;

    logic [TAG_W-1:0]    tag_mem  [FU_COUNT][DEPTH];
    word_t               data_mem [FU_COUNT][DEPTH];
    logic [PTR_W-1:0]    rd_ptr   [FU_COUNT];
    logic [PTR_W-1:0]    wr_ptr   [FU_COUNT];
    logic [CNT_W-1:0]    count    [FU_COUNT];
    logic [SRC_W-1:0]    rr_ptr;
    logic [SRC_W-1:0]    rr_next;
    logic                rst_done;

    logic [FU_COUNT-1:0] ready;
    logic [FU_COUNT-1:0] push;
    logic [FU_COUNT-1:0] pop;

    logic [WKUP_COUNT-1:0] ch_vld;
    logic [SRC_W-1:0]      ch_src   [WKUP_COUNT];
    logic [TAG_W-1:0]      ch_tag   [WKUP_COUNT];
    word_t                 ch_data  [WKUP_COUNT];
    word_t                 stage_data [WKUP_COUNT];

    logic [SRC_W:0]        scan_sum;
    logic [SRC_W-1:0]      scan_src;

    // Ready comes only from registered state; held low until the first edge after reset.
    always_comb begin
        for (int s = 0; s < FU_COUNT; s++) begin
            ready[s] = rst_done && (count[s] != CNT_W'(DEPTH));
            push[s]  = bus.fu_valid_i[s] && ready[s] && !flush;
        end
    end

    assign bus.fu_ready_o = ready;

    // Each channel takes the first not-yet-granted non-empty source in rotating order.
    always_comb begin
        pop      = '0;
        ch_vld   = '0;
        rr_next  = rr_ptr;
        scan_sum = '0;
        scan_src = '0;
        for (int c = 0; c < WKUP_COUNT; c++) begin
            ch_src[c] = '0;
            for (int k = 0; k < FU_COUNT; k++) begin
                scan_sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
                if (scan_sum >= (SRC_W+1)'(FU_COUNT)) begin
                    scan_sum = scan_sum - (SRC_W+1)'(FU_COUNT);
                end
                scan_src = scan_sum[SRC_W-1:0];
                if (!flush && !ch_vld[c] && !pop[scan_src] && (count[scan_src] != '0)) begin
                    ch_vld[c]     = 1'b1;
                    ch_src[c]     = scan_src;
                    pop[scan_src] = 1'b1;
                    rr_next       = (scan_src == SRC_W'(FU_COUNT - 1)) ? '0 : scan_src + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < WKUP_COUNT; c++) begin
            ch_tag[c]  = tag_mem[ch_src[c]][rd_ptr[ch_src[c]]];
            ch_data[c] = data_mem[ch_src[c]][rd_ptr[ch_src[c]]];
        end
    end

    // Entry storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        for (int s = 0; s < FU_COUNT; s++) begin
            if (push[s]) begin
                tag_mem[s][wr_ptr[s]]  <= bus.fu_tag_i[s];
                data_mem[s][wr_ptr[s]] <= bus.fu_data_i[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done         <= 1'b0;
            rr_ptr           <= '0;
            bus.wkup_valid_o <= '0;
            bus.wkup_tag_o   <= '0;
            bus.wkup_data_o  <= '0;
            for (int s = 0; s < FU_COUNT; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end
            for (int c = 0; c < WKUP_COUNT; c++) begin
                stage_data[c] <= '0;
            end
        end else begin
            rst_done <= 1'b1;
            rr_ptr   <= rr_next;
            for (int s = 0; s < FU_COUNT; s++) begin
                if (flush) begin
                    rd_ptr[s] <= '0;
                    wr_ptr[s] <= '0;
                    count[s]  <= '0;
                end else begin
                    if (push[s]) wr_ptr[s] <= wr_ptr[s] + 1'b1;
                    if (pop[s])  rd_ptr[s] <= rd_ptr[s] + 1'b1;
                    count[s] <= count[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
                end
            end
            // Data lags tag by one cycle: stage captures at grant, output copies it next edge.
            for (int c = 0; c < WKUP_COUNT; c++) begin
                bus.wkup_valid_o[c] <= ch_vld[c];
                if (ch_vld[c]) begin
                    bus.wkup_tag_o[c] <= ch_tag[c];
                    stage_data[c]     <= ch_data[c];
                end
                bus.wkup_data_o[c] <= stage_data[c];
            end
        end
    end

`ifdef WKUP_BCAST_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if ((|(bus.fu_valid_i & ~ready)) && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
